// File: rtl/dec_fpga_hold_if.sv
// Strobe/code request bus and registered decode outputs for dec_fpga_hold.
// The master side supplies the code; the slave side (the decoder) answers.
interface dec_fpga_hold_if;
   logic [2:0] Y;
   logic       Valid;
   logic       Strobe;
   logic       Ready;
   logic [7:0] D;
   logic       Active;
   logic       Overrun;
   logic [7:0] Count;

   modport master (
      output Y, Valid, Strobe,
      input  Ready, D, Active, Overrun, Count
   );

   modport slave (
      input  Y, Valid, Strobe,
      output Ready, D, Active, Overrun, Count
   );
endinterface

// File: rtl/dec_fpga_hold.sv
// Registered 3-to-8 decoder: shows a one-hot pattern for HOLD_CYCLES cycles,
// blanks for GAP_CYCLES cycles, then accepts the next strobed code.
module dec_fpga_hold #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned GAP_CYCLES  = 1
) (
   input logic           clk,
   input logic           rst,
   dec_fpga_hold_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SHOW = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

   logic [1:0] state_p1;
   logic [7:0] cnt_p1;
   logic [7:0] d_p1;
   logic       vld_p1;
   logic       ready_p1;
   logic       overrun_p1;
   logic [7:0] count_p1;

   function automatic logic [7:0] onehot(input logic [2:0] code, input logic vld);
      onehot = vld ? (8'h01 << code) : 8'h00;
   endfunction

   // Stage p1: every output is a register; Ready mirrors state==IDLE so
   // an overrun is simply a strobe seen while that register is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p1   <= S_IDLE;
         cnt_p1     <= 8'd0;
         d_p1       <= 8'h00;
         vld_p1     <= 1'b0;
         ready_p1   <= 1'b1;
         overrun_p1 <= 1'b0;
         count_p1   <= 8'd0;
      end else begin
         overrun_p1 <= bus.Strobe && !ready_p1;
         case (state_p1)
            S_IDLE: begin
               if (bus.Strobe) begin
                  d_p1     <= onehot(bus.Y, bus.Valid);
                  vld_p1   <= bus.Valid;
                  ready_p1 <= 1'b0;
                  count_p1 <= count_p1 + 8'd1;
                  cnt_p1   <= HOLD_LOAD;
                  state_p1 <= S_SHOW;
               end
            end
            S_SHOW: begin
               if (cnt_p1 != 8'd0) begin
                  cnt_p1 <= cnt_p1 - 8'd1;
               end else begin
                  d_p1   <= 8'h00;
                  vld_p1 <= 1'b0;
                  if (GAP_CYCLES != 0) begin
                     state_p1 <= S_GAP;
                     cnt_p1   <= GAP_LOAD;
                  end else begin
                     state_p1 <= S_IDLE;
                     ready_p1 <= 1'b1;
                  end
               end
            end
            S_GAP: begin
               if (cnt_p1 != 8'd0) begin
                  cnt_p1 <= cnt_p1 - 8'd1;
               end else begin
                  state_p1 <= S_IDLE;
                  ready_p1 <= 1'b1;
               end
            end
            default: begin
               state_p1 <= S_IDLE;
               cnt_p1   <= 8'd0;
               d_p1     <= 8'h00;
               vld_p1   <= 1'b0;
               ready_p1 <= 1'b1;
            end
         endcase
      end
   end

   assign bus.Ready   = ready_p1;
   assign bus.D       = d_p1;
   assign bus.Active  = vld_p1;
   assign bus.Overrun = overrun_p1;
   assign bus.Count   = count_p1;

endmodule
